// File: rtl/car_parking_system.sv
// Car-park gate controller: password-checking Moore FSM driving lamps and a status digit.
// Optional build macro CAR_PARKING_BLINK_EN makes the red lamp blink while the password is wrong.
`default_nettype none

module car_parking_system #(
  parameter int         WAIT_CYCLES = 3,
  parameter logic [1:0] PASS1       = 2'b01,
  parameter logic [1:0] PASS2       = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entrance_sensor,
  input  logic       exit_sensor,
  input  logic [1:0] password_user1,
  input  logic [1:0] password_user2,
  output logic       green_light,
  output logic       red_light,
  output logic [6:0] hex1
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_S     = 7'b0010010;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PASS  = 3'd1,
    S_WRONG_PASS = 3'd2,
    S_RIGHT_PASS = 3'd3,
    S_STOP       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_ok;

  assign pass_ok = (password_user1 == PASS1) && (password_user2 == PASS2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (entrance_sensor) state_d = S_WAIT_PASS;
      S_WAIT_PASS:  if (cnt_q == CNT_LAST) state_d = pass_ok ? S_RIGHT_PASS : S_WRONG_PASS;
      S_WRONG_PASS: if (pass_ok) state_d = S_RIGHT_PASS;
      S_RIGHT_PASS: begin
        // Both sensors at once means a second car is following through the open gate.
        if (entrance_sensor && exit_sensor) state_d = S_STOP;
        else if (exit_sensor)               state_d = S_IDLE;
      end
      S_STOP:       if (pass_ok) state_d = S_RIGHT_PASS;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT_PASS && state_d == S_WAIT_PASS)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CAR_PARKING_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = 1'b0;
    if (state_d == S_WRONG_PASS)
      blink_d = (state_q == S_WRONG_PASS) ? ~blink_q : 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end
`endif

  always_comb begin
    green_light = 1'b0;
    red_light   = 1'b0;
    hex1        = SEG_BLANK;
    unique case (state_q)
      S_IDLE: ;
      S_WAIT_PASS: begin
        red_light = 1'b1;
        hex1      = SEG_E;
      end
      S_WRONG_PASS: begin
`ifdef CAR_PARKING_BLINK_EN
        red_light = blink_q;
`else
        red_light = 1'b1;
`endif
        hex1      = SEG_F;
      end
      S_RIGHT_PASS: begin
        green_light = 1'b1;
        hex1        = SEG_G;
      end
      S_STOP: begin
        red_light = 1'b1;
        hex1      = SEG_S;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_car_parking_system.sv
// Directed self-checking bench for car_parking_system (default parameters).
`default_nettype none

module tb_car_parking_system;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entrance_sensor = 1'b0;
  logic       exit_sensor = 1'b0;
  logic [1:0] password_user1 = 2'b00;
  logic [1:0] password_user2 = 2'b00;
  logic       green_light;
  logic       red_light;
  logic [6:0] hex1;

  int errors = 0;
  int checks = 0;

  // Expected {green, red, hex1} per displayed status.
  localparam logic [8:0] O_IDLE  = {1'b0, 1'b0, 7'b1111111};
  localparam logic [8:0] O_WAIT  = {1'b0, 1'b1, 7'b0000110};
  localparam logic [8:0] O_WR1   = {1'b0, 1'b1, 7'b0001110};
`ifdef CAR_PARKING_BLINK_EN
  localparam logic [8:0] O_WR0   = {1'b0, 1'b0, 7'b0001110};
`else
  localparam logic [8:0] O_WR0   = {1'b0, 1'b1, 7'b0001110};
`endif
  localparam logic [8:0] O_RIGHT = {1'b1, 1'b0, 7'b1000010};
  localparam logic [8:0] O_STOP  = {1'b0, 1'b1, 7'b0010010};

  wire [8:0] obs = {green_light, red_light, hex1};

  car_parking_system dut (
    .clk             (clk),
    .reset           (reset),
    .entrance_sensor (entrance_sensor),
    .exit_sensor     (exit_sensor),
    .password_user1  (password_user1),
    .password_user2  (password_user2),
    .green_light     (green_light),
    .red_light       (red_light),
    .hex1            (hex1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL reset_t3 got=%h want=%h", obs, O_IDLE); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      entrance_sensor = i[0];
      exit_sensor     = i[1];
      password_user1  = 2'b01;
      password_user2  = 2'b10;
      #2.5;
      checks++;
      if (obs !== O_IDLE) begin
        $display("FAIL reset_hold_%0d got=%h want=%h", i, obs, O_IDLE); errors++;
      end
      @(posedge clk); #1;
    end
    entrance_sensor = 1'b0;
    exit_sensor     = 1'b0;
    reset           = 1'b1;
    step();
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL reset_release got=%h want=%h", obs, O_IDLE); errors++;
    end
  endtask

  task automatic test_right_pass();
    password_user1  = 2'b01;
    password_user2  = 2'b10;
    entrance_sensor = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      entrance_sensor = 1'b0;
      checks++;
      if (obs !== O_WAIT) begin
        $display("FAIL right_wait_%0d got=%h want=%h", i, obs, O_WAIT); errors++;
      end
    end
    step();
    checks++;
    if (obs !== O_RIGHT) begin
      $display("FAIL right_open got=%h want=%h", obs, O_RIGHT); errors++;
    end
    step();
    checks++;
    if (obs !== O_RIGHT) begin
      $display("FAIL right_hold got=%h want=%h", obs, O_RIGHT); errors++;
    end
    exit_sensor = 1'b1;
    step();
    exit_sensor = 1'b0;
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL right_exit got=%h want=%h", obs, O_IDLE); errors++;
    end
  endtask

  task automatic test_wrong_pass();
    password_user1  = 2'b01;
    password_user2  = 2'b11;
    entrance_sensor = 1'b1;
    step();
    entrance_sensor = 1'b0;
    step();
    step();
    checks++;
    if (obs !== O_WAIT) begin
      $display("FAIL wrong_last_wait got=%h want=%h", obs, O_WAIT); errors++;
    end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== (i[0] ? O_WR0 : O_WR1)) begin
        $display("FAIL wrong_blink_%0d got=%h want=%h", i, obs, (i[0] ? O_WR0 : O_WR1)); errors++;
      end
      step();
    end
    password_user2 = 2'b10;
    step();
    checks++;
    if (obs !== O_RIGHT) begin
      $display("FAIL wrong_to_right got=%h want=%h", obs, O_RIGHT); errors++;
    end
  endtask

  task automatic test_stop();
    entrance_sensor = 1'b1;
    exit_sensor     = 1'b1;
    password_user2  = 2'b00;
    step();
    entrance_sensor = 1'b0;
    exit_sensor     = 1'b0;
    checks++;
    if (obs !== O_STOP) begin
      $display("FAIL stop_enter got=%h want=%h", obs, O_STOP); errors++;
    end
    step();
    checks++;
    if (obs !== O_STOP) begin
      $display("FAIL stop_hold got=%h want=%h", obs, O_STOP); errors++;
    end
    password_user2 = 2'b10;
    step();
    checks++;
    if (obs !== O_RIGHT) begin
      $display("FAIL stop_to_right got=%h want=%h", obs, O_RIGHT); errors++;
    end
    exit_sensor = 1'b1;
    step();
    exit_sensor = 1'b0;
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL stop_exit got=%h want=%h", obs, O_IDLE); errors++;
    end
  endtask

  task automatic test_hold_async_reset();
    password_user1  = 2'b10;
    password_user2  = 2'b00;
    entrance_sensor = 1'b1;
    step();
    entrance_sensor = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[6:0] !== 7'b0001110 || obs[8] !== 1'b0) begin
        $display("FAIL hold_wrong_%0d got=%h want_hex=0e green=0", i, obs); errors++;
      end
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL async_reset got=%h want=%h", obs, O_IDLE); errors++;
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL async_release got=%h want=%h", obs, O_IDLE); errors++;
    end
  endtask

  task automatic test_late_glitch_and_idle_exit();
    password_user1  = 2'b01;
    password_user2  = 2'b11;
    entrance_sensor = 1'b1;
    step();
    entrance_sensor = 1'b0;
    password_user2  = 2'b10;
    step();
    password_user2  = 2'b11;
    step();
    step();
    checks++;
    if (obs !== O_WR1) begin
      $display("FAIL glitch_wrong got=%h want=%h", obs, O_WR1); errors++;
    end
    password_user2 = 2'b10;
    step();
    exit_sensor = 1'b1;
    step();
    checks++;
    if (obs !== O_IDLE) begin
      $display("FAIL glitch_exit got=%h want=%h", obs, O_IDLE); errors++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== O_IDLE) begin
        $display("FAIL idle_exit_only_%0d got=%h want=%h", i, obs, O_IDLE); errors++;
      end
    end
    exit_sensor = 1'b0;
  endtask

  initial begin
    test_reset();
    test_right_pass();
    test_wrong_pass();
    test_stop();
    test_hold_async_reset();
    test_late_glitch_and_idle_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
